bcd_stopwatch: RTL and testbench
================================

Name: bcd_stopwatch

Overview:
- Parametrised successor to the two-digit millisecond counter.
- Counts prescaled clock ticks into DIGITS cascaded BCD digits.
- Start/Stop/Clear run control, selectable wrap or saturate at full scale, sticky overflow flag, and a lap-hold display freeze.
- Sits between the board clock and the display/LED driver; Count feeds the display directly.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); full scale is 10^DIGITS-1.
- TICK_DIV, 100000, CLK cycles per count increment (>=1); 100000 at 100 MHz = 1 ms.
- WRAP, 1, 1 = roll over to zero at full scale; 0 = saturate and stop.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- Start  in  1  level/pulse; begin or resume counting.
- Stop  in  1  level/pulse; pause counting.
- Clear  in  1  zero count, prescaler and Overflow; return to IDLE.
- LapHold  in  1  level; 1 freezes Count output while counting continues internally.
- Count  out  4*DIGITS  BCD value; digit 0 (units) in bits [3:0], digit i in [4i+3:4i].
- Running  out  1  1 while in RUN.
- Overflow  out  1  sticky; set on wrap or saturation.

Behaviour:
- Reset (RST=1 at an edge): state=IDLE, internal count=0, prescaler=0, display register=0, Count=0, Running=0, Overflow=0. RST overrides all other inputs.
- States:
  - IDLE: no counting. Start -> RUN.
  - RUN: prescaler advances each cycle. Stop -> PAUSE.
  - PAUSE: prescaler and count hold their exact values. Start -> RUN; resume is cycle-accurate.
  - SAT: only when WRAP=0. Count holds all-9s; Start is ignored.
  - Clear from any state -> IDLE with count=0, prescaler=0, Overflow=0.
- Input priority at the same edge: RST > Clear > Stop > Start. Start and Stop together: Stop wins.
- Start while already in RUN: no effect; prescaler is not restarted.
- Prescaler: counts 0..TICK_DIV-1 in RUN only. When prescaler==TICK_DIV-1 in RUN, the next edge sets prescaler to 0 and increments the count.
- Timing: with Start sampled at edge k from IDLE, the first increment is visible after edge k+TICK_DIV, and one increment follows every TICK_DIV cycles after that. With TICK_DIV=1, the count increments on every RUN cycle.
- BCD increment: digit 0 +1. A digit at 9 becomes 0 and carries into the next digit; all carries resolve in the same cycle. No digit ever holds a value above 9.
- Full scale (all digits 9) plus a tick:
  - WRAP=1: count -> 0, Overflow set to 1, state stays RUN.
  - WRAP=0: count stays all-9s, Overflow set to 1, state -> SAT, Running=0.
- Clear wins over a tick on the same edge: result is count=0 and Overflow=0.
- Display register:
  - Updated from the internal count every cycle while LapHold=0. Count = display register, so Count lags the internal count by one cycle (registered output).
  - While LapHold=1 the display register holds its value; the internal count keeps running.
  - On LapHold falling, the display resumes tracking on the next edge.
  - Clear and RST force the display register to 0 even while LapHold=1.
- Running = (state==RUN), registered.
- Overflow is cleared only by RST or Clear.

Test Plan:
- DIGITS=2, TICK_DIV=4: RST, then Start pulse at edge k -> Count=0x01 after edge k+5 (registered display), 0x02 after k+9; Running=1 from k+1.
- DIGITS=2, TICK_DIV=1, WRAP=1: run 100 ticks from 0 -> Count passes 0x09->0x10 and 0x99->0x00; Overflow=1 from the wrap onward; Running stays 1.
- DIGITS=2, TICK_DIV=1, WRAP=0: run 120 cycles -> Count=0x99 held, Overflow=1, Running=0; Start ignored; Clear -> Count=0x00, Overflow=0, IDLE.
- TICK_DIV=4: Stop asserted with prescaler=2, wait 10 cycles, Start -> next increment lands exactly 2 RUN cycles after resume; Start and Stop together in RUN -> pause.
- LapHold=1 at Count=0x23 for 8 ticks -> Count stays 0x23; release -> Count=0x31 next cycle.
- Mid-run RST at Count=0x57 -> next cycle Count=0x00, Running=0, Overflow=0; Clear coincident with a tick -> Count=0x00.

Source files
------------

// File: rtl/bcd_stopwatch_if.sv
// Run-control and display bundle of the BCD stopwatch.
//   Start, Stop, Clear : run-control requests sampled on the rising clock edge
//   LapHold            : freezes the displayed Count while counting continues
//   Count              : BCD display value, digit 0 (units) in bits [3:0]
//   Running            : high while the stopwatch is counting
//   Overflow           : sticky, set when the count passes full scale
// master drives the controls, slave is the stopwatch itself.
interface bcd_stopwatch_if #(
    parameter int DIGITS = 2
);
    logic                  Start;
    logic                  Stop;
    logic                  Clear;
    logic                  LapHold;
    logic [4*DIGITS-1:0]   Count;
    logic                  Running;
    logic                  Overflow;

    modport master (
        output Start, Stop, Clear, LapHold,
        input  Count, Running, Overflow
    );

    modport slave (
        input  Start, Stop, Clear, LapHold,
        output Count, Running, Overflow
    );
endinterface

// File: rtl/bcd_stopwatch.sv
// Stopwatch counting prescaled clock ticks into DIGITS cascaded BCD digits.
//   CLK  : system clock, everything on the rising edge
//   RST  : synchronous active-high reset
//   bus  : slave side of bcd_stopwatch_if (run control, lap hold, display
//          Count, Running and sticky Overflow)
// Full scale is all nines; WRAP selects roll-over to zero or saturation.
module bcd_stopwatch #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 100000,
    parameter bit WRAP     = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    bcd_stopwatch_if.slave  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, SAT} state_t;

    state_t              state;
    logic [PW-1:0]       presc;
    logic [4*DIGITS-1:0] cnt;
    logic [4*DIGITS-1:0] cnt_inc;
    logic [4*DIGITS-1:0] disp;
    logic                running;
    logic                overflow;
    logic                full;
    logic                carry;
    logic [3:0]          digit;

    // Next BCD value: ripple a carry from the units digit upward so that
    // every digit settles within one cycle. full flags the all-nines value.
    always_comb begin
        cnt_inc = '0;
        full    = 1'b1;
        carry   = 1'b1;
        digit   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = cnt[4*i +: 4];
            if (digit != 4'd9) begin
                full = 1'b0;
            end
            if (carry) begin
                if (digit == 4'd9) begin
                    digit = 4'd0;
                end else begin
                    digit = digit + 4'd1;
                    carry = 1'b0;
                end
            end
            cnt_inc[4*i +: 4] = digit;
        end
    end

    // Run-control FSM with prescaler, count, display register and flags.
    // Clear behaves like reset for this block's state, so it also beats a
    // tick on the same edge. In RUN the Stop assignment comes first so that
    // reaching saturation on the same edge still lands in SAT.
    always_ff @(posedge CLK) begin
        if (RST || bus.Clear) begin
            state    <= IDLE;
            presc    <= '0;
            cnt      <= '0;
            disp     <= '0;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (!bus.LapHold) begin
                disp <= cnt;
            end
            case (state)
                IDLE, PAUSE: begin
                    if (bus.Start && !bus.Stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.Stop) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                    if (presc == LAST) begin
                        presc <= '0;
                        if (full) begin
                            overflow <= 1'b1;
                            if (WRAP) begin
                                cnt <= '0;
                            end else begin
                                state   <= SAT;
                                running <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Count    = disp;
    assign bus.Running  = running;
    assign bus.Overflow = overflow;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Testbench for bcd_stopwatch: three instances (TICK_DIV=4 wrap,
// TICK_DIV=1 wrap, TICK_DIV=1 saturate) with an integer-arithmetic model
// compared every cycle, plus hand-computed literal expectations.
module tb_bcd_stopwatch;
    logic clk = 1'b0;
    logic rst;
    logic start [3];
    logic stop  [3];
    logic clear [3];
    logic lap   [3];
    logic [7:0] count_out [3];
    logic       run_out   [3];
    logic       ovf_out   [3];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    int tdiv [3] = '{4, 1, 1};
    int wrp  [3] = '{1, 1, 0};

    // Model state: count value as a plain integer, mode 0 idle, 1 counting,
    // 2 paused, 3 saturated.
    int m_cnt  [3];
    int m_pre  [3];
    int m_mode [3];
    int m_ovf  [3];
    int m_disp [3];

    always #5 clk = ~clk;

    bcd_stopwatch_if #(.DIGITS(2)) bus0 ();
    bcd_stopwatch_if #(.DIGITS(2)) bus1 ();
    bcd_stopwatch_if #(.DIGITS(2)) bus2 ();

    assign bus0.Start = start[0];
    assign bus0.Stop = stop[0];
    assign bus0.Clear = clear[0];
    assign bus0.LapHold = lap[0];
    assign bus1.Start = start[1];
    assign bus1.Stop = stop[1];
    assign bus1.Clear = clear[1];
    assign bus1.LapHold = lap[1];
    assign bus2.Start = start[2];
    assign bus2.Stop = stop[2];
    assign bus2.Clear = clear[2];
    assign bus2.LapHold = lap[2];
    assign count_out[0] = bus0.Count;
    assign count_out[1] = bus1.Count;
    assign count_out[2] = bus2.Count;
    assign run_out[0] = bus0.Running;
    assign run_out[1] = bus1.Running;
    assign run_out[2] = bus2.Running;
    assign ovf_out[0] = bus0.Overflow;
    assign ovf_out[1] = bus1.Overflow;
    assign ovf_out[2] = bus2.Overflow;

    bcd_stopwatch #(.DIGITS(2), .TICK_DIV(4), .WRAP(1'b1)) dut0 (.CLK(clk), .RST(rst), .bus(bus0));
    bcd_stopwatch #(.DIGITS(2), .TICK_DIV(1), .WRAP(1'b1)) dut1 (.CLK(clk), .RST(rst), .bus(bus1));
    bcd_stopwatch #(.DIGITS(2), .TICK_DIV(1), .WRAP(1'b0)) dut2 (.CLK(clk), .RST(rst), .bus(bus2));

    function automatic logic [7:0] to_bcd(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Pulse the run controls of instance k for exactly one clock edge.
    task automatic applyStimulus(input int k, input logic s, input logic p, input logic c);
        start[k] = s;
        stop[k]  = p;
        clear[k] = c;
        @(negedge clk);
        start[k] = 1'b0;
        stop[k]  = 1'b0;
        clear[k] = 1'b0;
    endtask

    // Behavioural model, advanced on the same edge the DUTs sample.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst || clear[k]) begin
                m_cnt[k]  = 0;
                m_pre[k]  = 0;
                m_mode[k] = 0;
                m_ovf[k]  = 0;
                m_disp[k] = 0;
            end else begin
                if (!lap[k]) m_disp[k] = m_cnt[k];
                case (m_mode[k])
                    0, 2: if (start[k] && !stop[k]) m_mode[k] = 1;
                    1: begin
                        m_pre[k]++;
                        if (m_pre[k] == tdiv[k]) begin
                            m_pre[k] = 0;
                            if (m_cnt[k] == 99) begin
                                m_ovf[k] = 1;
                                if (wrp[k] != 0) m_cnt[k] = 0;
                                else m_mode[k] = 3;
                            end else begin
                                m_cnt[k]++;
                            end
                        end
                        if (stop[k] && m_mode[k] == 1) m_mode[k] = 2;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("model_count%0d", k), count_out[k], to_bcd(m_disp[k]));
                checkOutput($sformatf("model_running%0d", k), {7'b0, run_out[k]}, {7'b0, m_mode[k] == 1});
                checkOutput($sformatf("model_overflow%0d", k), {7'b0, ovf_out[k]}, {7'b0, m_ovf[k] != 0});
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            stop[k]  = 1'b0;
            clear[k] = 1'b0;
            lap[k]   = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        checkOutput("reset_count", count_out[0], 8'h00);
        checkOutput("reset_running", {7'b0, run_out[0]}, 8'h00);
        checkOutput("reset_overflow", {7'b0, ovf_out[0]}, 8'h00);

        // First-increment latency, TICK_DIV=4.
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("start_running", {7'b0, run_out[0]}, 8'h01);
        repeat (4) @(negedge clk);
        checkOutput("latency_k4", count_out[0], 8'h00);
        @(negedge clk);
        checkOutput("latency_k5", count_out[0], 8'h01);
        repeat (4) @(negedge clk);
        checkOutput("latency_k9", count_out[0], 8'h02);
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        checkOutput("stop_running", {7'b0, run_out[0]}, 8'h00);

        // Saturation, TICK_DIV=1, WRAP=0.
        applyStimulus(2, 1'b1, 1'b0, 1'b0);
        repeat (119) @(negedge clk);
        checkOutput("sat_count", count_out[2], 8'h99);
        checkOutput("sat_running", {7'b0, run_out[2]}, 8'h00);
        checkOutput("sat_overflow", {7'b0, ovf_out[2]}, 8'h01);
        applyStimulus(2, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("sat_start_ignored", {7'b0, run_out[2]}, 8'h00);
        checkOutput("sat_start_count", count_out[2], 8'h99);
        applyStimulus(2, 1'b0, 1'b0, 1'b1);
        checkOutput("sat_clear_count", count_out[2], 8'h00);
        checkOutput("sat_clear_overflow", {7'b0, ovf_out[2]}, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("sat_clear_idle", {7'b0, run_out[2]}, 8'h00);

        // Cycle-accurate pause/resume, TICK_DIV=4, paused with prescaler=2.
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        checkOutput("pause_running", {7'b0, run_out[0]}, 8'h00);
        repeat (10) @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("resume_running", {7'b0, run_out[0]}, 8'h01);
        repeat (2) @(negedge clk);
        checkOutput("resume_r2", count_out[0], 8'h00);
        @(negedge clk);
        checkOutput("resume_r3", count_out[0], 8'h01);
        applyStimulus(0, 1'b1, 1'b1, 1'b0);
        checkOutput("start_stop_running", {7'b0, run_out[0]}, 8'h00);
        repeat (8) @(negedge clk);
        checkOutput("start_stop_held", count_out[0], 8'h01);

        // Clear on the same edge as a tick, TICK_DIV=4.
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        checkOutput("clear_tick_count", count_out[0], 8'h00);
        checkOutput("clear_tick_running", {7'b0, run_out[0]}, 8'h00);
        @(negedge clk);
        checkOutput("clear_tick_after", count_out[0], 8'h00);

        // Wrap, TICK_DIV=1, WRAP=1.
        applyStimulus(1, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("wrap_09", count_out[1], 8'h09);
        @(negedge clk);
        checkOutput("wrap_10", count_out[1], 8'h10);
        repeat (88) @(negedge clk);
        checkOutput("wrap_98", count_out[1], 8'h98);
        checkOutput("wrap_pre_overflow", {7'b0, ovf_out[1]}, 8'h00);
        @(negedge clk);
        checkOutput("wrap_99", count_out[1], 8'h99);
        checkOutput("wrap_overflow", {7'b0, ovf_out[1]}, 8'h01);
        @(negedge clk);
        checkOutput("wrap_00", count_out[1], 8'h00);
        checkOutput("wrap_running", {7'b0, run_out[1]}, 8'h01);

        // Lap hold at 0x23 for 8 displayed cycles, then release.
        applyStimulus(1, 1'b0, 1'b0, 1'b1);
        checkOutput("clear_overflow", {7'b0, ovf_out[1]}, 8'h00);
        applyStimulus(1, 1'b1, 1'b0, 1'b0);
        repeat (24) @(negedge clk);
        checkOutput("lap_start", count_out[1], 8'h23);
        lap[1] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput("lap_hold", count_out[1], 8'h23);
        end
        lap[1] = 1'b0;
        @(negedge clk);
        checkOutput("lap_release", count_out[1], 8'h31);

        // Mid-run reset at 0x57 after the count has wrapped once.
        repeat (126) @(negedge clk);
        checkOutput("pre_reset_count", count_out[1], 8'h57);
        checkOutput("pre_reset_overflow", {7'b0, ovf_out[1]}, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_count", count_out[1], 8'h00);
        checkOutput("mid_reset_running", {7'b0, run_out[1]}, 8'h00);
        checkOutput("mid_reset_overflow", {7'b0, ovf_out[1]}, 8'h00);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
